// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / run-control block.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } run_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline status in, stage control and counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       id_rn, id_rm, id_rd;
    logic             id_use_rn, id_use_rm, id_use_rd;
    logic [3:0]       ex_rd;
    logic             ex_rf_enable, ex_load_instr;
    logic [3:0]       mem_rd;
    logic             mem_rf_enable;
    logic [3:0]       wb_rd;
    logic             wb_rf_enable;
    logic             ex_branch_taken, dm_busy, halt_req, step;
    logic             pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
    logic             nop_sel, if_id_flush;
    logic [1:0]       fwd_rn, fwd_rm, fwd_rd;
    logic             halted;
    logic [CNT_W-1:0] stall_count, flush_count;

    modport master (
        output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
               ex_rd, ex_rf_enable, ex_load_instr, mem_rd, mem_rf_enable,
               wb_rd, wb_rf_enable, ex_branch_taken, dm_busy, halt_req, step,
        input  pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
               nop_sel, if_id_flush, fwd_rn, fwd_rm, fwd_rd, halted,
               stall_count, flush_count
    );

    modport slave (
        input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
               ex_rd, ex_rf_enable, ex_load_instr, mem_rd, mem_rf_enable,
               wb_rd, wb_rf_enable, ex_branch_taken, dm_busy, halt_req, step,
        output pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
               nop_sel, if_id_flush, fwd_rn, fwd_rm, fwd_rd, halted,
               stall_count, flush_count
    );

endinterface

// File: rtl/fwd_select.sv
// Forwarding select for one ID source operand, youngest producer first.
module fwd_select
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] src,
    input  logic       use_src,
    input  logic [3:0] ex_rd,
    input  logic       ex_rf_enable,
    input  logic       ex_load_instr,
    input  logic [3:0] mem_rd,
    input  logic       mem_rf_enable,
    input  logic [3:0] wb_rd,
    input  logic       wb_rf_enable,
    output logic [1:0] sel
);

    // Loads in EX have no result yet, so they are never an EX bypass source
    always_comb begin
        sel = FWD_RF;
        if (!use_src || (src == REG_PC)) begin
            sel = FWD_RF;
        end else if (ex_rf_enable && !ex_load_instr && (ex_rd == src)) begin
            sel = FWD_EX;
        end else if (mem_rf_enable && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_rf_enable && (wb_rd == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: stalls, flushes, freezes, forwarding,
// halt/single-step run control and saturating stall/flush counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    run_state_e       state_r;
    logic             halted_r;
    logic [CNT_W-1:0] stall_count_r;
    logic [CNT_W-1:0] flush_count_r;
    logic             active_s;
    logic             load_use_s;
    logic             stall_inc_s;
    logic             flush_inc_s;
    logic [4:0]       enables_s;
    logic             nop_sel_s;
    logic             if_id_flush_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign active_s   = (state_r != HALT);
    assign load_use_s = bus.ex_load_instr &&
                        ((bus.id_use_rn && (bus.id_rn == bus.ex_rd)) ||
                         (bus.id_use_rm && (bus.id_rm == bus.ex_rd)) ||
                         (bus.id_use_rd && (bus.id_rd == bus.ex_rd)));

    // Hazard priority: freeze, then branch flush, then load-use stall
    always_comb begin
        enables_s     = 5'b11111;
        nop_sel_s     = 1'b0;
        if_id_flush_s = 1'b0;
        stall_inc_s   = 1'b0;
        flush_inc_s   = 1'b0;
        if (!active_s) begin
            enables_s = 5'b00000;
        end else if (bus.dm_busy) begin
            enables_s   = 5'b00000;
            stall_inc_s = 1'b1;
        end else if (bus.ex_branch_taken) begin
            nop_sel_s     = 1'b1;
            if_id_flush_s = 1'b1;
            flush_inc_s   = 1'b1;
        end else if (load_use_s) begin
            enables_s   = 5'b00111;
            nop_sel_s   = 1'b1;
            stall_inc_s = 1'b1;
        end else begin
            enables_s = 5'b11111;
        end
    end

    // Run-control FSM; step wins over a dropped halt_req while halted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= RUN;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    state_r  <= bus.halt_req ? HALT : RUN;
                    halted_r <= bus.halt_req;
                end
                HALT: begin
                    if (bus.step) begin
                        state_r  <= STEP;
                        halted_r <= 1'b0;
                    end else if (!bus.halt_req) begin
                        state_r  <= RUN;
                        halted_r <= 1'b0;
                    end else begin
                        state_r  <= HALT;
                        halted_r <= 1'b1;
                    end
                end
                STEP: begin
                    state_r  <= bus.halt_req ? HALT : RUN;
                    halted_r <= bus.halt_req;
                end
                default: begin
                    state_r  <= RUN;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_r <= {CNT_W{1'b0}};
            flush_count_r <= {CNT_W{1'b0}};
        end else begin
            stall_count_r <= stall_inc_s ? sat_inc(stall_count_r) : stall_count_r;
            flush_count_r <= flush_inc_s ? sat_inc(flush_count_r) : flush_count_r;
        end
    end

    fwd_select u_fwd_rn (
        .src(bus.id_rn), .use_src(bus.id_use_rn),
        .ex_rd(bus.ex_rd), .ex_rf_enable(bus.ex_rf_enable), .ex_load_instr(bus.ex_load_instr),
        .mem_rd(bus.mem_rd), .mem_rf_enable(bus.mem_rf_enable),
        .wb_rd(bus.wb_rd), .wb_rf_enable(bus.wb_rf_enable),
        .sel(bus.fwd_rn)
    );

    fwd_select u_fwd_rm (
        .src(bus.id_rm), .use_src(bus.id_use_rm),
        .ex_rd(bus.ex_rd), .ex_rf_enable(bus.ex_rf_enable), .ex_load_instr(bus.ex_load_instr),
        .mem_rd(bus.mem_rd), .mem_rf_enable(bus.mem_rf_enable),
        .wb_rd(bus.wb_rd), .wb_rf_enable(bus.wb_rf_enable),
        .sel(bus.fwd_rm)
    );

    fwd_select u_fwd_rd (
        .src(bus.id_rd), .use_src(bus.id_use_rd),
        .ex_rd(bus.ex_rd), .ex_rf_enable(bus.ex_rf_enable), .ex_load_instr(bus.ex_load_instr),
        .mem_rd(bus.mem_rd), .mem_rf_enable(bus.mem_rf_enable),
        .wb_rd(bus.wb_rd), .wb_rf_enable(bus.wb_rf_enable),
        .sel(bus.fwd_rd)
    );

    assign bus.pc_enable     = enables_s[4];
    assign bus.if_id_enable  = enables_s[3];
    assign bus.id_ex_enable  = enables_s[2];
    assign bus.ex_mem_enable = enables_s[1];
    assign bus.mem_wb_enable = enables_s[0];
    assign bus.nop_sel       = nop_sel_s;
    assign bus.if_id_flush   = if_id_flush_s;
    assign bus.halted        = halted_r;
    assign bus.stall_count   = stall_count_r;
    assign bus.flush_count   = flush_count_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [3:0] rn, rm, rd;
        logic [2:0] use_v;
        logic [3:0] ex_rd;
        logic       ex_rf, ex_ld;
        logic [3:0] mem_rd;
        logic       mem_rf;
        logic [3:0] wb_rd;
        logic       wb_rf;
        logic       br, busy;
        logic [4:0] en;
        logic       nop, fl;
        logic [5:0] fwd;
    } vec_t;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;
    vec_t vecs [15];

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [12:0] outs();
        return {bus.pc_enable, bus.if_id_enable, bus.id_ex_enable, bus.ex_mem_enable,
                bus.mem_wb_enable, bus.nop_sel, bus.if_id_flush,
                bus.fwd_rn, bus.fwd_rm, bus.fwd_rd};
    endfunction

    function automatic logic [4:0] ens();
        return {bus.pc_enable, bus.if_id_enable, bus.id_ex_enable,
                bus.ex_mem_enable, bus.mem_wb_enable};
    endfunction

    task automatic apply(input vec_t v);
        bus.id_rn = v.rn; bus.id_rm = v.rm; bus.id_rd = v.rd;
        {bus.id_use_rn, bus.id_use_rm, bus.id_use_rd} = v.use_v;
        bus.ex_rd = v.ex_rd; bus.ex_rf_enable = v.ex_rf; bus.ex_load_instr = v.ex_ld;
        bus.mem_rd = v.mem_rd; bus.mem_rf_enable = v.mem_rf;
        bus.wb_rd = v.wb_rd; bus.wb_rf_enable = v.wb_rf;
        bus.ex_branch_taken = v.br; bus.dm_busy = v.busy;
    endtask

    task automatic clear_inputs();
        apply('0);
        bus.halt_req = 1'b0;
        bus.step     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [CNT_W-1:0] s0;
        n_total = 0;
        n_pass  = 0;
        //            rn     rm     rd     use     exrd  exrf  exld  memrd memrf wbrd  wbrf  br    busy  en        nop   fl    fwd
        vecs[0]  = '{4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 6'b000000};
        vecs[1]  = '{4'd2, 4'd0, 4'd0, 3'b100, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'b00111, 1'b1, 1'b0, 6'b000000};
        vecs[2]  = '{4'd0, 4'd0, 4'd5, 3'b001, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'b00111, 1'b1, 1'b0, 6'b000000};
        vecs[3]  = '{4'd2, 4'd0, 4'd0, 3'b000, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 6'b000000};
        vecs[4]  = '{4'd0, 4'd3, 4'd0, 3'b010, 4'd3, 1'b1, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 6'b000100};
        vecs[5]  = '{4'd0, 4'd15,4'd0, 3'b010, 4'd15,1'b1, 1'b0, 4'd15,1'b1, 4'd15,1'b1, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 6'b000000};
        vecs[6]  = '{4'd0, 4'd3, 4'd0, 3'b010, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 6'b001000};
        vecs[7]  = '{4'd0, 4'd3, 4'd0, 3'b010, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 6'b001100};
        vecs[8]  = '{4'd0, 4'd3, 4'd0, 3'b010, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 5'b00111, 1'b1, 1'b0, 6'b001000};
        vecs[9]  = '{4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 5'b11111, 1'b1, 1'b1, 6'b000000};
        vecs[10] = '{4'd2, 4'd0, 4'd0, 3'b100, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 5'b11111, 1'b1, 1'b1, 6'b000000};
        vecs[11] = '{4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b0, 6'b000000};
        vecs[12] = '{4'd1, 4'd2, 4'd4, 3'b111, 4'd1, 1'b1, 1'b0, 4'd2, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 6'b011011};
        vecs[13] = '{4'd1, 4'd0, 4'd0, 3'b000, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 6'b000000};
        vecs[14] = '{4'd7, 4'd0, 4'd0, 3'b100, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 6'b100000};

        // Reset state
        reset = 1'b0;
        clear_inputs();
        #3;
        chk("reset_halted", {31'd0, bus.halted}, 32'd0);
        chk("reset_stall",  {28'd0, bus.stall_count}, 32'd0);
        chk("reset_flush",  {28'd0, bus.flush_count}, 32'd0);
        chk("reset_outs",   {19'd0, outs()}, {19'd0, 13'b11111_0_0_000000});
        tick();
        reset = 1'b1;
        tick();

        // Combinational vector table (RUN state)
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i]);
            #1;
            chk($sformatf("vec%0d", i), {19'd0, outs()},
                {19'd0, vecs[i].en, vecs[i].nop, vecs[i].fl, vecs[i].fwd});
        end

        // Async reset clears counters mid-cycle
        clear_inputs();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_stall_clr", {28'd0, bus.stall_count}, 32'd0);
        chk("rst_flush_clr", {28'd0, bus.flush_count}, 32'd0);
        #1;
        reset = 1'b1;
        tick();

        // Load-use stall for exactly one cycle, then MEM forwarding
        bus.id_rn = 4'd2; bus.id_use_rn = 1'b1;
        bus.ex_rd = 4'd2; bus.ex_rf_enable = 1'b1; bus.ex_load_instr = 1'b1;
        #1;
        chk("lu_stall_en", {27'd0, ens()}, {27'd0, 5'b00111});
        chk("lu_stall_nop", {31'd0, bus.nop_sel}, 32'd1);
        chk("lu_stall_cnt0", {28'd0, bus.stall_count}, 32'd0);
        tick();
        chk("lu_stall_cnt1", {28'd0, bus.stall_count}, 32'd1);
        bus.ex_rf_enable = 1'b0; bus.ex_load_instr = 1'b0; bus.ex_rd = 4'd0;
        bus.mem_rd = 4'd2; bus.mem_rf_enable = 1'b1;
        #1;
        chk("lu_next_fwd", {30'd0, bus.fwd_rn}, 32'd2);
        chk("lu_next_en", {27'd0, ens()}, {27'd0, 5'b11111});
        tick();
        chk("lu_next_cnt", {28'd0, bus.stall_count}, 32'd1);

        // Branch held across a 3-cycle data-memory freeze
        clear_inputs();
        bus.dm_busy = 1'b1; bus.ex_branch_taken = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("frz_en%0d", c), {25'd0, ens(), bus.nop_sel, bus.if_id_flush}, 32'd0);
            tick();
        end
        bus.dm_busy = 1'b0;
        #1;
        chk("frz_flush", {25'd0, ens(), bus.nop_sel, bus.if_id_flush}, {25'd0, 7'b11111_1_1});
        tick();
        bus.ex_branch_taken = 1'b0;
        chk("frz_stall_cnt", {28'd0, bus.stall_count}, 32'd4);
        chk("frz_flush_cnt", {28'd0, bus.flush_count}, 32'd1);

        // Halt, counters hold, single step, resume
        bus.halt_req = 1'b1;
        #1;
        chk("halt_req_cycle_en", {27'd0, ens()}, {27'd0, 5'b11111});
        tick();
        chk("halted", {31'd0, bus.halted}, 32'd1);
        bus.dm_busy = 1'b1; bus.ex_branch_taken = 1'b1;
        #1;
        chk("halt_outs", {25'd0, ens(), bus.nop_sel, bus.if_id_flush}, 32'd0);
        tick();
        chk("halt_cnt_hold", {24'd0, bus.stall_count, bus.flush_count}, {24'd0, 4'd4, 4'd1});
        bus.dm_busy = 1'b0; bus.ex_branch_taken = 1'b0;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        chk("step_halted", {31'd0, bus.halted}, 32'd0);
        chk("step_en", {27'd0, ens()}, {27'd0, 5'b11111});
        tick();
        chk("step_rehalt", {31'd0, bus.halted}, 32'd1);
        chk("step_rehalt_en", {27'd0, ens()}, 32'd0);
        bus.halt_req = 1'b0;
        tick();
        chk("resume_halted", {31'd0, bus.halted}, 32'd0);
        chk("resume_en", {27'd0, ens()}, {27'd0, 5'b11111});

        // Reset during STEP
        bus.halt_req = 1'b1;
        tick();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        bus.dm_busy = 1'b1;
        reset = 1'b0;
        #1;
        chk("rst_step_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_step_cnts", {24'd0, bus.stall_count, bus.flush_count}, 32'd0);
        bus.halt_req = 1'b0;
        bus.dm_busy  = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rst_step_run", {26'd0, bus.halted, ens()}, {26'd0, 1'b0, 5'b11111});

        // Stall counter saturation
        s0 = bus.stall_count;
        chk("sat_start", {28'd0, s0}, 32'd0);
        bus.dm_busy = 1'b1;
        for (int c = 0; c < 18; c++) tick();
        chk("sat_stall", {28'd0, bus.stall_count}, 32'd15);
        chk("sat_flush", {28'd0, bus.flush_count}, 32'd0);
        bus.dm_busy = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
